// File: rtl/jb_aes128_iter_ctrl_pkg.sv
// Shared types, round constants, S-box and byte-level helpers for the
// iterative AES-128 encryption controller and its key-step sub-module.
package jb_aes128_iter_ctrl_pkg;

  typedef logic [127:0] block128_t;
  typedef logic [7:0]   byte_t;
  // Element 0 is bus byte 0 (bits 127:120), i.e. state[row 0][col 0].
  typedef byte_t [0:15] bytes16_t;
  typedef byte_t [0:9]  roundconstants_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  localparam int AES128_ROUNDS = 10;

  localparam roundconstants_t RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox_byte(input byte_t x);
    return SBOX[x];
  endfunction

  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    byte_t a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round constant for round index 1..10; zero outside that range.
  function automatic byte_t rcon_at(input logic [3:0] rnd);
    byte_t r;
    r = 8'h00;
    if (rnd >= 4'd1 && rnd <= 4'd10) begin
      r = RCON[rnd - 4'd1];
    end
    return r;
  endfunction

endpackage

// File: rtl/jb_aes128_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one and the round constant. Purely combinational.
module jb_aes128_key_step
  import jb_aes128_iter_ctrl_pkg::*;
(
  input  block128_t rkey_in,
  input  byte_t     rcon,
  output block128_t rkey_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rkey_in;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    assign sub_w[8*gi +: 8] = sbox_byte(rot_w[8*gi +: 8]);
  end

  assign temp_w = sub_w ^ {rcon, 24'h000000};
  assign n0 = w0 ^ temp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rkey_out = {n0, n1, n2, n3};

endmodule

// File: rtl/jb_aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock through a shared round
// datapath, key schedule computed on the fly, active-low nStart/nDone handshake.
module jb_aes128_iter_ctrl
  import jb_aes128_iter_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         nStart,
  input  logic [127:0] key,
  input  logic [127:0] blockin,
  output logic         nDone,
  output logic         busy,
  output logic [127:0] blockout,
  output logic [3:0]   round
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_num_rounds
    $error("jb_aes128_iter_ctrl: NUM_ROUNDS must be 10 (AES-128)");
  end

  ctrl_state_e fsm_q, fsm_d;
  block128_t   state_q, state_d;
  block128_t   rkey_q, rkey_d;
  block128_t   blockout_q, blockout_d;
  logic [3:0]  rcnt_q, rcnt_d;

  block128_t rk_next;
  block128_t full_out, last_out, round_out;
  bytes16_t  st_b, sb_b, sr_b, mc_b;
  logic      is_last;

  jb_aes128_key_step u_key_step (
    .rkey_in  (rkey_q),
    .rcon     (rcon_at(rcnt_q)),
    .rkey_out (rk_next)
  );

  assign st_b = state_q;

  // SubBytes then ShiftRows: new[row r][col c] = old[row r][col (c+r)%4].
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
    assign sb_b[gi] = sbox_byte(st_b[gi]);
    assign sr_b[gi] = sb_b[SRC];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    assign mc_b[4*gi +: 4] = mix_column(sr_b[4*gi +: 4]);
  end

  // Full and last rounds are evaluated in parallel; the last one skips MixColumns.
  assign full_out  = block128_t'(mc_b) ^ rk_next;
  assign last_out  = block128_t'(sr_b) ^ rk_next;
  assign is_last   = (rcnt_q == 4'(NUM_ROUNDS));
  assign round_out = is_last ? last_out : full_out;

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    rkey_d     = rkey_q;
    blockout_d = blockout_q;
    rcnt_d     = rcnt_q;
    case (fsm_q)
      IDLE: begin
        if (!nStart) begin
          state_d = blockin ^ key;
          rkey_d  = key;
          rcnt_d  = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        rkey_d  = rk_next;
        if (is_last) begin
          blockout_d = last_out;
          rcnt_d     = 4'd0;
          fsm_d      = DONE;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      rkey_q     <= '0;
      blockout_q <= '0;
      rcnt_q     <= 4'd0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      rkey_q     <= rkey_d;
      blockout_q <= blockout_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign busy     = (fsm_q == ROUND);
  assign nDone    = (fsm_q != DONE);
  assign round    = busy ? rcnt_q : 4'd0;
  assign blockout = blockout_q;

endmodule

// File: tb/tb_jb_aes128_iter_ctrl.sv
// Self-checking bench: known FIPS-197 vectors plus random blocks compared with
// an algorithmic AES-128 model (S-box derived from GF(2^8) inverse + affine map).
module tb_jb_aes128_iter_ctrl;

  logic         clk = 1'b0;
  logic         Rst;
  logic         nStart;
  logic [127:0] key;
  logic [127:0] blockin;
  logic         nDone;
  logic         busy;
  logic [127:0] blockout;
  logic [3:0]   round;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  jb_aes128_iter_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .nStart   (nStart),
    .key      (key),
    .blockin  (blockin),
    .nDone    (nDone),
    .busy     (busy),
    .blockout (blockout),
    .round    (round)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Passive monitor: sampled on the falling edge, half a cycle from the active edge.
  int           cyc = 0;
  int           ndone_cnt = 0;
  int           busy_cnt = 0;
  int           bo_glitch = 0;
  logic [127:0] prev_bo = '0;
  int           done_cyc[$];
  logic [127:0] done_bo[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nDone === 1'b0) begin
      ndone_cnt <= ndone_cnt + 1;
      done_cyc.push_back(cyc);
      done_bo.push_back(blockout);
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (busy === 1'b1 && blockout !== prev_bo) bo_glitch <= bo_glitch + 1;
    prev_bo <= blockout;
  end

  // ---------------- reference model ----------------
  logic [7:0]   sb_m [256];
  logic [127:0] rk_m [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sb_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]], sb_m[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb_m[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Starts one block from IDLE and waits (bounded) for nDone; lat counts edges after accept.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           output int lat, output logic [127:0] ct,
                           output logic [127:0] rk1, output logic [127:0] rk10,
                           output bit round_ok, output logic nd_after);
    nStart = 1'b0; key = k; blockin = p;
    tick();
    nStart = 1'b1;
    lat = -1; rk1 = '0; round_ok = (int'(round) == 1);
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 1) rk1 = dut.rkey_q;
      if (nDone === 1'b0) begin
        lat = j;
        break;
      end
      if (int'(round) != j + 1) round_ok = 1'b0;
    end
    ct = blockout;
    rk10 = dut.rkey_q;
    tick();
    nd_after = nDone;
    $display("blk key=%h pt=%h ct=%h lat=%0d", k, p, ct, lat);
  endtask

  int           lat, idle_bad, base_nd, base_busy, qb, d1, d2;
  logic [127:0] ct, rk1, rk10, exp_ct;
  bit           rok, found;
  logic         nda;

  initial begin
    Rst = 1'b1; nStart = 1'b1; key = '0; blockin = '0;
    build_sbox();
    tick(); tick();
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_ndone", 128'(nDone), 128'd1);
    check_eq("rst_blockout", blockout, 128'd0);
    check_eq("rst_round", 128'(round), 128'd0);
    check_eq("rst_state", dut.state_q, 128'd0);
    check_eq("rst_rkey", dut.rkey_q, 128'd0);
    Rst = 1'b0;

    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b0 || nDone !== 1'b1 || blockout !== '0 || round !== 4'd0) idle_bad++;
    end
    check_eq("idle_stable", 128'(idle_bad), 128'd0);

    // FIPS-197 C.1: nDone low after edge N+10 (the 11th edge counting the accept).
    run_block(C1_KEY, C1_PT, lat, ct, rk1, rk10, rok, nda);
    check_eq("c1_latency", 128'(lat), 128'd10);
    check_eq("c1_ct", ct, C1_CT);
    check_eq("c1_ndone_width", 128'(nda), 128'd1);
    check_eq("c1_round_seq", 128'(rok), 128'd1);

    // Appendix B with round-key probes.
    run_block(B_KEY, B_PT, lat, ct, rk1, rk10, rok, nda);
    check_eq("b_ct", ct, B_CT);
    check_eq("b_rk1", rk1, B_RK1);
    check_eq("b_rk10", rk10, B_RK10);
    check_eq("b_latency", 128'(lat), 128'd10);

    // Ignored starts during ROUND/DONE, inputs corrupted after accept.
    base_nd = ndone_cnt; base_busy = busy_cnt;
    nStart = 1'b0; key = C1_KEY; blockin = C1_PT;
    tick();
    nStart = 1'b1; key = '1; blockin = '1;
    for (int j = 1; j <= 26; j++) begin
      tick();
      nStart = (int'(round) == 3 || int'(round) == 10) ? 1'b0 : 1'b1;
    end
    nStart = 1'b1;
    $display("ign ndone=%0d busy=%0d bo=%h", ndone_cnt - base_nd, busy_cnt - base_busy, blockout);
    check_eq("ign_ndone_pulses", 128'(ndone_cnt - base_nd), 128'd1);
    check_eq("ign_busy_cycles", 128'(busy_cnt - base_busy), 128'd10);
    check_eq("ign_ct", blockout, C1_CT);

    // Back-to-back: nStart held low for 30 cycles.
    qb = done_cyc.size();
    nStart = 1'b0; key = C1_KEY; blockin = C1_PT;
    repeat (30) tick();
    nStart = 1'b1;
    repeat (20) tick();
    d1 = (done_cyc.size() >= qb + 2) ? done_cyc[qb+1] - done_cyc[qb] : -1;
    d2 = (done_cyc.size() >= qb + 3) ? done_cyc[qb+2] - done_cyc[qb+1] : -1;
    $display("b2b pulses=%0d gap1=%0d gap2=%0d", done_cyc.size() - qb, d1, d2);
    check_eq("b2b_pulses", 128'(done_cyc.size() - qb), 128'd3);
    check_eq("b2b_gap1", 128'(d1), 128'd12);
    check_eq("b2b_gap2", 128'(d2), 128'd12);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("b2b_ct%0d", i), (done_bo.size() > qb + i) ? done_bo[qb+i] : '0, C1_CT);
    end

    // Asynchronous reset at round 5.
    nStart = 1'b0; key = C1_KEY; blockin = C1_PT;
    tick();
    nStart = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (int'(round) == 5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("rst_reach_r5", 128'(found), 128'd1);
    #1 Rst = 1'b1;
    #1;
    check_eq("arst_busy", 128'(busy), 128'd0);
    check_eq("arst_ndone", 128'(nDone), 128'd1);
    check_eq("arst_blockout", blockout, 128'd0);
    check_eq("arst_round", 128'(round), 128'd0);
    base_nd = ndone_cnt;
    tick(); tick();
    Rst = 1'b0;
    repeat (20) tick();
    check_eq("arst_no_pulse", 128'(ndone_cnt - base_nd), 128'd0);
    check_eq("arst_bo_hold", blockout, 128'd0);
    $display("arst recovered ndone=%0d bo=%h", ndone_cnt - base_nd, blockout);
    run_block(C1_KEY, C1_PT, lat, ct, rk1, rk10, rok, nda);
    check_eq("arst_c1_ct", ct, C1_CT);
    check_eq("arst_c1_lat", 128'(lat), 128'd10);

    // Random blocks against the model.
    for (int i = 0; i < 8; i++) begin
      logic [127:0] rk, rp;
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = aes_ref(rk, rp);
      run_block(rk, rp, lat, ct, rk1, rk10, rok, nda);
      check_eq($sformatf("rnd%0d_ct", i), ct, exp_ct);
      check_eq($sformatf("rnd%0d_rk1", i), rk1, rk_m[1]);
      check_eq($sformatf("rnd%0d_rk10", i), rk10, rk_m[10]);
      check_eq($sformatf("rnd%0d_lat", i), 128'(lat), 128'd10);
      check_eq($sformatf("rnd%0d_round_seq", i), 128'(rok), 128'd1);
    end

    check_eq("bo_stable_in_round", 128'(bo_glitch), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
